keypad_digit_buffer: RTL and testbench
======================================

# keypad_digit_buffer

Parametrised successor to the keypad encoder / T-flip-flop clock chain / shift-register array path. It samples a raw keypad bus on a single clock, detects each new key press, priority-encodes it, and writes the digit into the next free slot of a DIGITS-deep buffer. It adds backspace, clear, a lock mode, and full/overflow reporting. It sits between the keypad inputs and the code-compare / display logic.

## Interface
- NUM_KEYS, 10: number of raw key lines. Key index i encodes digit value i.
- DIGITS, 6: buffer depth in digits.
- DIGIT_W, 4: bits per stored digit. Must satisfy 2^DIGIT_W >= NUM_KEYS; a violation is an elaboration error.
- CNT_W, $clog2(DIGITS+1): width of the fill count (derived; do not override).
- clk  in  1  system clock, all state updates on the rising edge.
- rst_ui  in  1  asynchronous active-high reset.
- key  in  NUM_KEYS  raw key levels, 1 = pressed.
- mode  in  1  0 = capture, 1 = lock (presses ignored, buffer held).
- bksp  in  1  backspace request, level sampled each cycle.
- clr  in  1  clear request, level sampled each cycle.
- digits  out  DIGITS*DIGIT_W  slot s in bits [s*DIGIT_W +: DIGIT_W]; slot 0 holds the first digit entered.
- count  out  CNT_W  number of valid slots, 0..DIGITS.
- full  out  1  count == DIGITS.
- press  out  1  one-cycle pulse when a digit is written.
- overflow  out  1  one-cycle pulse when a press is discarded because the buffer is full.

## Operation
- Input stage: key is registered into key_q every cycle. The async key lines get no other synchroniser. Debounce is upstream.
- any_q = |key_q. Encoded value = highest set index of key_q, zero-extended to DIGIT_W.
- Press FSM, two states:
  - IDLE: any_q=1 → go to HELD and raise a press event.
  - HELD: stay until any_q=0, then go to IDLE.
  - Adding or changing keys while in HELD raises no new event. A key must be fully released before the next press is accepted.
- FSM transitions occur in both modes. A key held across a lock→capture switch does not register.
- Per-cycle action, in priority order:
  1. clr: all slots ← 0, count ← 0.
  2. bksp and count>0: slot[count-1] ← 0, count ← count-1. If count=0, no-op.
  3. Press event, mode=0, count<DIGITS: slot[count] ← encoded value, count ← count+1, press ← 1.
  4. Press event, mode=0, count==DIGITS: buffer unchanged, overflow ← 1.
  5. Press event with mode=1: ignored. No press, no overflow.
- A press event that coincides with clr or bksp is consumed (the FSM still moves to HELD) and is not written.
- clr and bksp are level inputs. Holding bksp for N cycles removes up to N digits.
- Slots at index ≥ count always read 0.
- full is registered and derived from the next count, so it updates in the same cycle as count.

## Timing
- Reset (rst_ui=1, asynchronous): key_q=0, FSM=IDLE, digits=0, count=0, full=0, press=0, overflow=0. Reset asserted mid-entry discards everything immediately.
- Press latency: key set before edge k → key_q valid after edge k → digit, count, and press visible after edge k+1 (2 edges).
- press and overflow last exactly one cycle per accepted press event.
- Minimum press spacing: key low for ≥1 sampled edge between presses. A press → release → press sequence at 1-cycle granularity yields 2 writes.
- clr and bksp take effect on the first rising edge they are sampled high (latency 1 edge).
- Count wrap cannot occur: count saturates at DIGITS and never goes below 0.

## Test plan
- Reset, then press and release key[2], key[1], key[9], key[3], key[5], key[4], each held 3 cycles with 2 released cycles between → digits = {4,5,3,9,1,2} (slot5..slot0), count=6, full=1, six press pulses.
- Full buffer, press key[7] → overflow pulses once, digits unchanged, count=6.
- After entering 2,1,9, assert bksp for 1 cycle → count=2, slot2=0. Hold bksp for 3 cycles → count=0, no underflow.
- Hold key[3] and add key[8] without releasing → exactly one write, value 3. Press key[3] and key[8] together from idle → value 8.
- Set mode=1 and press key[6] → no press, no write. Set mode=0 while still holding key[6] → no write until release and re-press.
- Raise clr in the same cycle as a press event → count=0, no press pulse. Assert rst_ui mid-press → all outputs 0 asynchronously.

Source files
------------

// File: rtl/keypad_digit_buffer.sv
// keypad_digit_buffer: registers a raw keypad bus, detects each new key
// press, priority-encodes it and appends the digit to a DIGITS-deep buffer.
// Supports backspace, clear, a lock mode and full/overflow reporting.
module keypad_digit_buffer #(
    parameter int NUM_KEYS = 10,
    parameter int DIGITS   = 6,
    parameter int DIGIT_W  = 4,
    parameter int CNT_W    = $clog2(DIGITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_ui,
    input  logic [NUM_KEYS-1:0]       key,
    input  logic                      mode,
    input  logic                      bksp,
    input  logic                      clr,
    output logic [DIGITS*DIGIT_W-1:0] digits,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      press,
    output logic                      overflow,
    output logic                      state_dbg
);

    // Every key index must be representable as a stored digit.
    if ((2 ** DIGIT_W) < NUM_KEYS) begin : g_bad_digit_w
        $error("keypad_digit_buffer: 2**DIGIT_W must be >= NUM_KEYS");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } press_state_t;

    press_state_t          state;
    logic [NUM_KEYS-1:0]   key_q;
    logic                  any_q;
    logic [DIGIT_W-1:0]    enc;
    logic                  press_evt;
    logic [DIGIT_W-1:0]    slot [DIGITS];

    // Single input register on the raw key lines; debounce lives upstream.
    always_ff @(posedge clk or posedge rst_ui) begin
        if (rst_ui) key_q <= '0;
        else        key_q <= key;
    end

    assign any_q = |key_q;

    // Priority encoder: the highest pressed key index wins.
    always_comb begin
        enc = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_q[i]) enc = DIGIT_W'(i);
        end
    end

    // A press event is the first cycle any key is seen while idle.
    assign press_evt = (state == ST_IDLE) && any_q;
    assign state_dbg = state;

    // Press FSM: runs in both modes, so a key held through lock->capture
    // stays in HELD and is not counted until released and pressed again.
    always_ff @(posedge clk or posedge rst_ui) begin
        if (rst_ui) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (any_q)  state <= ST_HELD;
                ST_HELD: if (!any_q) state <= ST_IDLE;
                default:             state <= ST_IDLE;
            endcase
        end
    end

    // Buffer update: clr beats bksp beats a press; a press coinciding with
    // clr or bksp is consumed without being written.
    always_ff @(posedge clk or posedge rst_ui) begin
        if (rst_ui) begin
            for (int s = 0; s < DIGITS; s++) slot[s] <= '0;
            count    <= '0;
            full     <= 1'b0;
            press    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            press    <= 1'b0;
            overflow <= 1'b0;
            if (clr) begin
                for (int s = 0; s < DIGITS; s++) slot[s] <= '0;
                count <= '0;
                full  <= 1'b0;
            end else if (bksp) begin
                if (count != '0) begin
                    for (int s = 0; s < DIGITS; s++) begin
                        if (CNT_W'(s) == count - CNT_W'(1)) slot[s] <= '0;
                    end
                    count <= count - CNT_W'(1);
                    full  <= 1'b0;
                end
            end else if (press_evt && !mode) begin
                if (count < CNT_W'(DIGITS)) begin
                    for (int s = 0; s < DIGITS; s++) begin
                        if (CNT_W'(s) == count) slot[s] <= enc;
                    end
                    count <= count + CNT_W'(1);
                    full  <= ((count + CNT_W'(1)) == CNT_W'(DIGITS));
                    press <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Flatten the slot array onto the output bus, slot 0 in the low bits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_pack
        assign digits[g*DIGIT_W +: DIGIT_W] = slot[g];
    end

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Directed bench for keypad_digit_buffer: a vector table for entry and
// backspace, then hand-written sequences for the multi-cycle corner cases.
module tb_keypad_digit_buffer;

    logic        clk = 1'b0;
    logic        rst_ui;
    logic [9:0]  key;
    logic        mode, bksp, clr;
    logic [23:0] digits;
    logic [2:0]  count;
    logic        full, press, overflow, state_dbg;

    int n_chk  = 0;
    int n_pass = 0;
    int press_cnt = 0;
    int ovf_cnt   = 0;

    keypad_digit_buffer dut (
        .clk(clk), .rst_ui(rst_ui), .key(key), .mode(mode), .bksp(bksp),
        .clr(clr), .digits(digits), .count(count), .full(full),
        .press(press), .overflow(overflow), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  key;
        logic        bksp;
        logic [23:0] exp_digits;
        logic [2:0]  exp_count;
        logic        exp_press;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic tick(input logic [9:0] k, input logic m, input logic b, input logic c);
        key = k; mode = m; bksp = b; clr = c;
        @(posedge clk);
        #1;
        press_cnt += int'(press);
        ovf_cnt   += int'(overflow);
    endtask

    task automatic do_reset();
        key = '0; mode = 0; bksp = 0; clr = 0;
        rst_ui = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_ui = 1'b0;
    endtask

    task automatic press_key(input int idx, input logic m);
        repeat (3) tick(10'(1) << idx, m, 0, 0);
        repeat (2) tick('0, m, 0, 0);
    endtask

    initial begin
        tbl[0]  = '{10'h004, 0, 24'h000000, 3'd0, 0};
        tbl[1]  = '{10'h000, 0, 24'h000002, 3'd1, 1};
        tbl[2]  = '{10'h002, 0, 24'h000002, 3'd1, 0};
        tbl[3]  = '{10'h000, 0, 24'h000012, 3'd2, 1};
        tbl[4]  = '{10'h200, 0, 24'h000012, 3'd2, 0};
        tbl[5]  = '{10'h000, 0, 24'h000912, 3'd3, 1};
        tbl[6]  = '{10'h000, 1, 24'h000012, 3'd2, 0};
        tbl[7]  = '{10'h000, 0, 24'h000012, 3'd2, 0};
        tbl[8]  = '{10'h000, 1, 24'h000002, 3'd1, 0};
        tbl[9]  = '{10'h000, 1, 24'h000000, 3'd0, 0};
        tbl[10] = '{10'h000, 1, 24'h000000, 3'd0, 0};
        tbl[11] = '{10'h000, 0, 24'h000000, 3'd0, 0};

        do_reset();
        chk("reset_digits", 32'(digits), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_flags", {28'd0, full, press, overflow, state_dbg}, 0);

        // Entry of 2,1,9 then single and held backspace.
        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].key, 0, tbl[i].bksp, 0);
            chk($sformatf("tbl%0d_digits", i), 32'(digits), 32'(tbl[i].exp_digits));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_press", i), 32'(press), 32'(tbl[i].exp_press));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 0);
            chk($sformatf("tbl%0d_full", i), 32'(full), 0);
        end

        // Fill the buffer with 2,1,9,3,5,4.
        do_reset();
        press_cnt = 0; ovf_cnt = 0;
        press_key(2, 0);
        press_key(1, 0);
        press_key(9, 0);
        press_key(3, 0);
        press_key(5, 0);
        chk("fill5_full", 32'(full), 0);
        press_key(4, 0);
        chk("fill_digits", 32'(digits), 32'h453912);
        chk("fill_count", 32'(count), 6);
        chk("fill_full", 32'(full), 1);
        chk("fill_presses", press_cnt, 6);

        // Overflow on a full buffer.
        press_cnt = 0; ovf_cnt = 0;
        press_key(7, 0);
        chk("ovf_pulses", ovf_cnt, 1);
        chk("ovf_presses", press_cnt, 0);
        chk("ovf_digits", 32'(digits), 32'h453912);
        chk("ovf_count", 32'(count), 6);
        chk("ovf_full", 32'(full), 1);

        // Rollover: hold 3 then add 8 -> single write of 3.
        do_reset();
        press_cnt = 0;
        tick(10'h008, 0, 0, 0);
        tick(10'h108, 0, 0, 0);
        chk("roll_first", 32'(digits), 32'h3);
        repeat (2) tick(10'h108, 0, 0, 0);
        repeat (2) tick('0, 0, 0, 0);
        chk("roll_count", 32'(count), 1);
        chk("roll_presses", press_cnt, 1);

        // Simultaneous 3+8 from idle -> highest index 8.
        repeat (3) tick(10'h108, 0, 0, 0);
        repeat (2) tick('0, 0, 0, 0);
        chk("prio_digits", 32'(digits), 32'h83);
        chk("prio_count", 32'(count), 2);

        // Lock mode, then unlock while still holding the key.
        press_cnt = 0; ovf_cnt = 0;
        repeat (3) tick(10'h040, 1, 0, 0);
        chk("lock_state", 32'(state_dbg), 1);
        repeat (3) tick(10'h040, 0, 0, 0);
        chk("lock_nopress", press_cnt, 0);
        chk("lock_count", 32'(count), 2);
        repeat (2) tick('0, 0, 0, 0);
        press_key(6, 0);
        chk("unlock_presses", press_cnt, 1);
        chk("unlock_digits", 32'(digits), 32'h683);
        chk("unlock_ovf", ovf_cnt, 0);

        // clr in the same cycle as a press event.
        tick(10'h020, 0, 0, 0);
        tick(10'h020, 0, 0, 1);
        chk("clr_count", 32'(count), 0);
        chk("clr_digits", 32'(digits), 0);
        chk("clr_press", 32'(press), 0);
        chk("clr_state", 32'(state_dbg), 1);
        tick(10'h020, 0, 0, 0);
        repeat (2) tick('0, 0, 0, 0);
        chk("clr_consumed", 32'(count), 0);

        // Asynchronous reset right after a write, before any further edge.
        tick(10'h004, 0, 0, 0);
        tick(10'h004, 0, 0, 0);
        chk("pre_rst_count", 32'(count), 1);
        rst_ui = 1'b1;
        #2;
        chk("arst_count", 32'(count), 0);
        chk("arst_digits", 32'(digits), 0);
        chk("arst_flags", {28'd0, full, press, overflow, state_dbg}, 0);
        @(posedge clk); #1;
        rst_ui = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
